rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset release sequencer.
// A start pulse, or a software re-sequence request, releases NUM_STAGES
// active-low resets one at a time. Releases are spaced STAGE_DLY cycles apart.
// When the last stage is released the block raises a completion level and a
// one-cycle interrupt pulse.
// Optional macro RST_SEQ_ACK_EN: after each release the sequencer waits for
// stage_ack[idx], or for an ACK_TMO-cycle timeout that sets a sticky
// timeout_err flag, before it moves on.
module rst_seq_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int DLY_W      = 8,
    parameter int STAGE_DLY  = 16,
    parameter int ACK_TMO    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  soft_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rstn,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  seq_irq,
    output logic                  timeout_err
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    // Parameters outside their legal range stop elaboration.
    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
            $error("rst_seq_ctrl: NUM_STAGES must be 1..16");
        end
        if (DLY_W < 1 || DLY_W > 31) begin : g_bad_dly_w
            $error("rst_seq_ctrl: DLY_W must be 1..31");
        end
        if (STAGE_DLY < 1 || STAGE_DLY > (2**DLY_W) - 1) begin : g_bad_stage_dly
            $error("rst_seq_ctrl: STAGE_DLY must be 1..2**DLY_W-1");
        end
        if (ACK_TMO < 1 || ACK_TMO > (2**DLY_W) - 1) begin : g_bad_ack_tmo
            $error("rst_seq_ctrl: ACK_TMO must be 1..2**DLY_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [DLY_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [NUM_STAGES-1:0]   stage_rstn_reg, stage_rstn_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    irq_reg, irq_next;
    logic                    tmo_reg, tmo_next;

    // One-hot mask of the stage currently being sequenced.
    logic [NUM_STAGES-1:0]   cur_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_cur_mask
            assign cur_mask[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef RST_SEQ_ACK_EN
    localparam logic [DLY_W-1:0] TMO_LAST = DLY_W'(ACK_TMO - 1);
    // Acknowledge of the stage that was just released.
    logic ack_sel;
    assign ack_sel = |(stage_ack & cur_mask);
`else
    // Acks are not used in this build; fold them into a dummy net.
    logic unused_ack;
    assign unused_ack = ^stage_ack;
`endif

    // State and registered outputs; rst has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            stage_rstn_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            irq_reg        <= 1'b0;
            tmo_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            stage_rstn_reg <= stage_rstn_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            irq_reg        <= irq_next;
            tmo_reg        <= tmo_next;
        end
    end

    // Next-state logic: soft_req restarts from any state, otherwise walk the stages.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        stage_rstn_next = stage_rstn_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        irq_next        = 1'b0;
        tmo_next        = tmo_reg;

        if (soft_req) begin
            state_next      = DELAY;
            cnt_next        = '0;
            idx_next        = '0;
            stage_rstn_next = '0;
            busy_next       = 1'b1;
            done_next       = 1'b0;
            tmo_next        = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = DELAY;
                        cnt_next   = '0;
                        idx_next   = '0;
                        busy_next  = 1'b1;
                    end
                end
                DELAY: begin
                    if (cnt_reg == DLY_LAST) begin
                        stage_rstn_next = stage_rstn_reg | cur_mask;
                        cnt_next        = '0;
`ifdef RST_SEQ_ACK_EN
                        state_next      = WAIT_ACK;
`else
                        if (idx_reg == IDX_LAST) begin
                            state_next = DONE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            irq_next   = 1'b1;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
`endif
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`ifdef RST_SEQ_ACK_EN
                WAIT_ACK: begin
                    if (ack_sel || cnt_reg == TMO_LAST) begin
                        // A timeout advances exactly like an ack but leaves a sticky flag.
                        if (!ack_sel) begin
                            tmo_next = 1'b1;
                        end
                        cnt_next = '0;
                        if (idx_reg == IDX_LAST) begin
                            state_next = DONE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            irq_next   = 1'b1;
                        end else begin
                            idx_next   = idx_reg + 1'b1;
                            state_next = DELAY;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`endif
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output logic: every port comes straight from a register.
    always_comb begin
        stage_rstn = stage_rstn_reg;
        busy       = busy_reg;
        seq_done   = done_reg;
        seq_irq    = irq_reg;
`ifdef RST_SEQ_ACK_EN
        timeout_err = tmo_reg;
`else
        timeout_err = 1'b0;
`endif
    end

`ifndef RST_SEQ_ACK_EN
    // The timeout flag is never set in this build.
    logic unused_tmo;
    assign unused_tmo = tmo_reg;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl in the default build (no ack handshake).
// Main instance: NUM_STAGES=4, STAGE_DLY=16.
// Corner instance: NUM_STAGES=1, STAGE_DLY=1.
module tb_rst_seq_ctrl;

    localparam int NS = 4;
    localparam int SD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          soft_req = 1'b0;
    logic [NS-1:0] stage_ack = '0;
    logic [NS-1:0] stage_rstn;
    logic          busy, seq_done, seq_irq, timeout_err;

    logic          start1 = 1'b0;
    logic          soft_req1 = 1'b0;
    logic [0:0]    stage_ack1 = '0;
    logic [0:0]    stage_rstn1;
    logic          busy1, seq_done1, seq_irq1, timeout_err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(.NUM_STAGES(NS), .DLY_W(8), .STAGE_DLY(SD), .ACK_TMO(255)) dut (
        .clk(clk), .rst(rst), .start(start), .soft_req(soft_req),
        .stage_ack(stage_ack), .stage_rstn(stage_rstn), .busy(busy),
        .seq_done(seq_done), .seq_irq(seq_irq), .timeout_err(timeout_err)
    );

    rst_seq_ctrl #(.NUM_STAGES(1), .DLY_W(8), .STAGE_DLY(1), .ACK_TMO(255)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .soft_req(soft_req1),
        .stage_ack(stage_ack1), .stage_rstn(stage_rstn1), .busy(busy1),
        .seq_done(seq_done1), .seq_irq(seq_irq1), .timeout_err(timeout_err1)
    );

    // Advance one clock edge, then sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {stage_rstn, busy, seq_done, seq_irq, timeout_err}.
    // k is the number of edges since the sequence start edge (k=0 is the start edge itself).
    function automatic logic [NS+3:0] exp_vec(int k);
        int n;
        logic [NS-1:0] r;
        n = k / SD;
        if (n > NS) n = NS;
        r = NS'((1 << n) - 1);
        return {r, (k < NS*SD), (k >= NS*SD), (k == NS*SD), 1'b0};
    endfunction

    function automatic logic [NS+3:0] got_vec();
        return {stage_rstn, busy, seq_done, seq_irq, timeout_err};
    endfunction

    task automatic test_reset();
        logic [NS+3:0] got;
        logic [4:0]    got1;
        rst = 1'b1;
        tick();
        tick();
        got  = got_vec();
        got1 = {stage_rstn1, busy1, seq_done1, seq_irq1, timeout_err1};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset main got=%b want=%b", got, {(NS+4){1'b0}});
        end
        total++;
        if (got1 !== 5'b0) begin
            bad++;
            $display("FAIL reset corner got=%b want=00000", got1);
        end
        rst = 1'b0;
        tick();
        got = got_vec();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset idle_hold got=%b want=%b", got, {(NS+4){1'b0}});
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [NS+3:0] got;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) tick();
            got = got_vec();
            total++;
            if (got !== exp_vec(k)) begin
                bad++;
                $display("FAIL basic k=%0d got=%b want=%b", k, got, exp_vec(k));
            end
        end
        $display("test_basic: done");
    endtask

    task automatic test_mid_reset();
        logic [NS+3:0] got;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) tick();
        got = got_vec();
        total++;
        if (got !== exp_vec(40)) begin
            bad++;
            $display("FAIL mid_reset pre got=%b want=%b", got, exp_vec(40));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = got_vec();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL mid_reset cleared got=%b want=%b", got, {(NS+4){1'b0}});
        end
        // Still in IDLE: nothing moves without a start.
        for (int k = 0; k < 20; k++) tick();
        got = got_vec();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL mid_reset idle got=%b want=%b", got, {(NS+4){1'b0}});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) tick();
            got = got_vec();
            total++;
            if (got !== exp_vec(k)) begin
                bad++;
                $display("FAIL mid_reset replay k=%0d got=%b want=%b", k, got, exp_vec(k));
            end
        end
        $display("test_mid_reset: done");
    endtask

    task automatic test_priority();
        logic [NS+3:0] got;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        start    = 1'b1;
        soft_req = 1'b1;
        tick();
        start    = 1'b0;
        soft_req = 1'b0;
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) tick();
            got = got_vec();
            total++;
            if (got !== exp_vec(k)) begin
                bad++;
                $display("FAIL priority k=%0d got=%b want=%b", k, got, exp_vec(k));
            end
        end
        $display("test_priority: done");
    endtask

    task automatic test_soft_in_done();
        logic [NS+3:0] got;
        // Now in DONE from the previous test.
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) tick();
            got = got_vec();
            total++;
            if (got !== exp_vec(k)) begin
                bad++;
                $display("FAIL soft_in_done k=%0d got=%b want=%b", k, got, exp_vec(k));
            end
        end
        $display("test_soft_in_done: done");
    endtask

    task automatic test_ignored_start();
        logic [NS+3:0] got;
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        for (int k = 0; k <= 72; k++) begin
            if (k > 0) tick();
            got = got_vec();
            total++;
            if (got !== exp_vec(k)) begin
                bad++;
                $display("FAIL ignored_start k=%0d got=%b want=%b", k, got, exp_vec(k));
            end
            // Pulses land in DELAY (k=20, 47) and in DONE (k=66, 70).
            start = (k == 20 || k == 47 || k == 66 || k == 70);
        end
        start = 1'b0;
        $display("test_ignored_start: done");
    endtask

    task automatic test_soft_held();
        logic [NS+3:0] got;
        soft_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            got = got_vec();
            total++;
            if (got !== exp_vec(0)) begin
                bad++;
                $display("FAIL soft_held i=%0d got=%b want=%b", i, got, exp_vec(0));
            end
        end
        soft_req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            got = got_vec();
            total++;
            if (got !== exp_vec(k)) begin
                bad++;
                $display("FAIL soft_held_rel k=%0d got=%b want=%b", k, got, exp_vec(k));
            end
        end
        $display("test_soft_held: done");
    endtask

    task automatic test_corner();
        logic [4:0] got1;
        logic [4:0] want [3];
        want[0] = 5'b01000;  // start edge: busy only
        want[1] = 5'b10110;  // start+1: released, done, irq
        want[2] = 5'b10100;  // irq back low, done held
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            got1 = {stage_rstn1, busy1, seq_done1, seq_irq1, timeout_err1};
            total++;
            if (got1 !== want[k]) begin
                bad++;
                $display("FAIL corner k=%0d got=%b want=%b", k, got1, want[k]);
            end
        end
        $display("test_corner: done");
    endtask

    initial begin
        test_reset();
        test_corner();
        test_basic();
        test_mid_reset();
        test_priority();
        test_soft_in_done();
        test_ignored_start();
        test_soft_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
